mp_add_sequencer: RTL
=====================

# mp_add_sequencer

Multi-precision add/subtract sequencer built around one instance of the team's 32-bit ripple adder `add_with_carry_32bit`. Operands of `WORDS` × 32 bits stream in one word per cycle, least-significant word first. The block chains the carry between words in a register and streams result words out through a one-entry output buffer with valid/ready backpressure. It sits between the operand buffers and the result writeback in the ALU path, so one narrow adder serves arbitrarily wide arithmetic.

## Interface
- `WORDS`, default 4: number of 32-bit words per operand; must be ≥1.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin an operation; sampled only in IDLE.
- `sub` in 1: 0 = A+B, 1 = A−B; latched on `start`.
- `cin_ext` in 1: carry-in for the first word of an add; ignored for sub; latched on `start`.
- `in_valid` in 1: operand word pair valid.
- `in_ready` out 1: sequencer accepts the word pair this cycle.
- `in_a`, `in_b` in 32: operand words, LSW first.
- `out_valid` out 1: result word valid.
- `out_ready` in 1: consumer accepts the result word.
- `out_sum` out 32: result word.
- `out_last` out 1: the current result word is the most-significant word.
- `out_carry` out 1: final carry (add) or borrow (sub); meaningful only while `out_last`=1, else 0.
- `busy` out 1: the state is not IDLE.
- `done` out 1: one-cycle pulse when the operation completes.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: `start`=1 causes the block to latch `sub` and load `carry_q` with `sub ? 1 : cin_ext`. The word counter is cleared and the FSM goes to RUN.
- RUN: `in_ready = !out_valid || out_ready`. On an input handshake:
  - The adder computes `a = in_a`, `b = sub ? ~in_b : in_b`, `cin = carry_q`.
  - `out_sum` is loaded with the adder sum and `out_valid` is set.
  - `carry_q` is loaded with the adder cout and the counter increments.
- Last word (counter = `WORDS`−1): `out_last`=1, `out_carry = cout ^ sub`, and the FSM goes to DRAIN.
- DRAIN: `in_ready`=0. When the last word's output handshake completes, the FSM goes to IDLE and `done`=1 for that one cycle.
- The output buffer holds `out_sum`, `out_last` and `out_carry` stable while `out_valid && !out_ready`.
- Behaviour at boundaries:
  - `start` while busy is ignored.
  - `in_valid` in IDLE or DRAIN is not accepted.
  - `start` and `in_valid` together in IDLE: the word is not accepted. The first word can be accepted in the following cycle.
- Arithmetic: all 32-bit, unsigned modulo 2^(32·WORDS). Subtraction is two's complement. Borrow=1 means A<B unsigned.
- `WORDS`=1: the first word is also the last, and the FSM goes RUN→DRAIN on the first accept.

## Timing
- Reset (`rst_n`=0 at a rising edge), applied mid-operation or not, gives:
  - state IDLE;
  - `in_ready`=0, `out_valid`=0;
  - `out_sum`=0, `out_last`=0, `out_carry`=0;
  - `busy`=0, `done`=0;
  - `carry_q`=0, counter=0.

  Any partial result is discarded.
- Let `start` be sampled at edge T. Then `busy`=1 and `in_ready`=1 from T+1.
- Input accepted at edge k → `out_valid`=1 with that word's sum from k+1. The latency is 1 cycle.
- With `in_valid` and `out_ready` held high, throughput is 1 word/cycle. The last output handshake occurs at edge T+1+WORDS.
- `done` is high in the cycle after the last output handshake. `busy` is 0 from that same cycle.
- Back-to-back operation: a new `start` is accepted in the cycle after `done`.
- `in_ready` and `out_valid` never depend combinationally on `in_valid`. `in_ready` does depend combinationally on `out_ready`.

## Configuration
- `MP_ADD_OVF_EN`: when defined, the block adds an output `out_ovf` (1 bit, reset 0), valid with `out_last`. It reports signed overflow of the full-width operation: `out_ovf` = (a[31] == b'[31]) && (sum[31] != a[31]), evaluated on the last word, where b' is the possibly inverted B.
- When `MP_ADD_OVF_EN` is undefined, the port and its logic are absent. All other behaviour is identical.

## Test plan
- Add with carry ripple across all words:
  - Stimulus: `WORDS`=4, `sub`=0, `cin_ext`=0, A words all FFFFFFFF, B = {0,0,0,00000001} (LSW=1).
  - Required response: sums 00000000 ×4, `out_last` on word 4, `out_carry`=1, `done` at cycle T+6.
- Add with external carry-in:
  - Stimulus: `cin_ext`=1, A LSW=12345678, B LSW=87654321, all upper words 0.
  - Required response: words 9999999A, 0, 0, 0, `out_carry`=0.
- Subtract with borrow:
  - Stimulus: `sub`=1, A=0, B LSW=1.
  - Required response: words FFFFFFFF ×4, `out_carry` (borrow)=1. With A=B, words are 0 ×4 and borrow=0.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 3 cycles after word 2.
  - Required response: `out_sum` is held, `in_ready`=0 throughout, no word is lost or duplicated, and the final results are unchanged.
- Synchronous reset mid-operation:
  - Stimulus: `rst_n`=0 for one edge after word 2 is accepted.
  - Required response: all outputs are at reset values the next cycle. A subsequent full add (case 1) is correct.
- Overflow, with `MP_ADD_OVF_EN` defined:
  - Stimulus: A = {7FFFFFFF, FFFFFFFF, FFFFFFFF, FFFFFFFF}, B LSW=1, upper words 0.
  - Required response: top word 80000000, `out_ovf`=1, `out_carry`=0.

Source files
------------

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: one 32-bit adder, carry chained across WORDS words.
// Optional signed-overflow output guarded by MP_ADD_OVF_EN.

module add_with_carry_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
endmodule

module mp_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        sub_i,
    input  logic        cin_ext_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_a_i,
    input  logic [31:0] in_b_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_sum_o,
    output logic        out_last_o,
    output logic        out_carry_o,
`ifdef MP_ADD_OVF_EN
    output logic        out_ovf_o,
`endif
    output logic        busy_o,
    output logic        done_o
);
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t          state_q;
    logic            carry_q, sub_q;
    logic [CW-1:0]   cnt_q;
    logic            out_valid_q, out_last_q, out_carry_q, done_q;
    logic [31:0]     out_sum_q;
    logic [31:0]     b_mod, sum;
    logic            cout, in_hs, out_hs, is_last;

    // Subtraction is A + ~B + 1; the +1 comes from carry_q being preset on start.
    assign b_mod = sub_q ? ~in_b_i : in_b_i;

    add_with_carry_32bit u_add (
        .a_i   (in_a_i),
        .b_i   (b_mod),
        .cin_i (carry_q),
        .sum_o (sum),
        .cout_o(cout)
    );

    assign in_ready_o = (state_q == RUN) && (!out_valid_q || out_ready_i);
    assign in_hs      = in_valid_i && in_ready_o;
    assign out_hs     = out_valid_q && out_ready_i;
    assign is_last    = (cnt_q == CW'(WORDS - 1));

`ifdef MP_ADD_OVF_EN
    logic out_ovf_q;
    assign out_ovf_o = out_ovf_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef MP_ADD_OVF_EN
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (out_hs) out_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    sub_q   <= sub_i;
                    carry_q <= sub_i | cin_ext_i;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: if (in_hs) begin
                    out_valid_q <= 1'b1;
                    out_sum_q   <= sum;
                    out_last_q  <= is_last;
                    // Borrow is the inverse of the final carry when subtracting.
                    out_carry_q <= is_last & (cout ^ sub_q);
`ifdef MP_ADD_OVF_EN
                    out_ovf_q   <= is_last & (in_a_i[31] == b_mod[31]) & (sum[31] != in_a_i[31]);
`endif
                    carry_q     <= cout;
                    cnt_q       <= cnt_q + CW'(1);
                    if (is_last) state_q <= DRAIN;
                end
                DRAIN: if (out_hs) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_sum_o   = out_sum_q;
    assign out_last_o  = out_last_q;
    assign out_carry_o = out_carry_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
endmodule
